// File: rtl/modexpa7_fifo_mover_pkg.sv
// Shared definitions for the modexpa7 FIFO mover: FSM state encodings and
// the FIFO size derivation.
package modexpa7_fifo_mover_pkg;

    typedef enum logic [1:0] {
        FSM_STATE_IDLE  = 2'd0,
        FSM_STATE_CLEAR = 2'd1,
        FSM_STATE_RUN   = 2'd2,
        FSM_STATE_DONE  = 2'd3
    } fsm_state_t;

    function automatic int num_words(input int depth_bits);
        return 1 << depth_bits;
    endfunction

endpackage

// File: rtl/modexpa7_fifo_mover.sv
// Copies one multi-word operand from a source bank to a destination bank
// through the flagless modexpa7 distributed-RAM FIFO, honouring dst_ready.
module modexpa7_fifo_mover #(
    parameter int OPERAND_ADDR_WIDTH = 5,
    parameter int DEPTH_BITS         = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    output logic                          rdy,
    input  logic [OPERAND_ADDR_WIDTH-1:0] n_num_words,
    output logic [OPERAND_ADDR_WIDTH-1:0] src_addr,
    output logic                          src_en,
    output logic                          fifo_rst,
    output logic                          fifo_wr_en,
    output logic                          fifo_rd_en,
    input  logic                          dst_ready,
    output logic [OPERAND_ADDR_WIDTH-1:0] dst_addr,
    output logic                          dst_wr_en
);
    import modexpa7_fifo_mover_pkg::*;

    localparam int AW        = OPERAND_ADDR_WIDTH;
    localparam int NUM_WORDS = num_words(DEPTH_BITS);
    localparam logic [DEPTH_BITS:0] OCC_FULL = (DEPTH_BITS+1)'(NUM_WORDS);

    fsm_state_t          state_q, state_d;
    logic [AW-1:0]       n_q, n_d;
    logic [AW:0]         src_cnt_q, src_cnt_d;
    logic [AW:0]         dst_cnt_q, dst_cnt_d;
    logic [DEPTH_BITS:0] inflight_q, inflight_d;
    logic [DEPTH_BITS:0] stored_q, stored_d;
    logic                src_en_q, src_en_d;
    logic                wr_en_q, wr_en_d;
    logic                dst_wr_q, dst_wr_d;
    logic                rdy_q, rdy_d;
    logic                fifo_rst_q, fifo_rst_d;
    logic                rd_en;

    assign rd_en = (state_q == FSM_STATE_RUN) && (stored_q != '0) && dst_ready;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        src_cnt_d  = '0;
        dst_cnt_d  = '0;
        inflight_d = '0;
        stored_d   = '0;
        case (state_q)
            FSM_STATE_IDLE: begin
                if (ena) begin
                    state_d = FSM_STATE_CLEAR;
                    n_d     = n_num_words;
                end
            end
            FSM_STATE_CLEAR: state_d = FSM_STATE_RUN;
            FSM_STATE_RUN: begin
                if (dst_wr_q && (dst_cnt_q == {1'b0, n_q}))
                    state_d = FSM_STATE_DONE;
            end
            FSM_STATE_DONE: state_d = FSM_STATE_IDLE;
            default:        state_d = FSM_STATE_IDLE;
        endcase

        if (state_q == FSM_STATE_RUN) begin
            src_cnt_d  = src_cnt_q + (AW+1)'(src_en_q);
            dst_cnt_d  = dst_cnt_q + (AW+1)'(dst_wr_q);
            inflight_d = inflight_q + (DEPTH_BITS+1)'(src_en_q) - (DEPTH_BITS+1)'(rd_en);
            stored_d   = stored_q + (DEPTH_BITS+1)'(wr_en_q) - (DEPTH_BITS+1)'(rd_en);
        end

        // Source issue is decided on next-cycle counts so the strobe can be
        // registered yet still resume the cycle right after a pop.
        src_en_d   = (state_d == FSM_STATE_RUN) && (src_cnt_d <= {1'b0, n_d})
                     && (inflight_d < OCC_FULL);
        wr_en_d    = src_en_q;
        dst_wr_d   = rd_en;
        rdy_d      = (state_d == FSM_STATE_IDLE);
        fifo_rst_d = (state_d == FSM_STATE_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FSM_STATE_IDLE;
            n_q        <= '0;
            src_cnt_q  <= '0;
            dst_cnt_q  <= '0;
            inflight_q <= '0;
            stored_q   <= '0;
            src_en_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            dst_wr_q   <= 1'b0;
            rdy_q      <= 1'b1;
            fifo_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            src_cnt_q  <= src_cnt_d;
            dst_cnt_q  <= dst_cnt_d;
            inflight_q <= inflight_d;
            stored_q   <= stored_d;
            src_en_q   <= src_en_d;
            wr_en_q    <= wr_en_d;
            dst_wr_q   <= dst_wr_d;
            rdy_q      <= rdy_d;
            fifo_rst_q <= fifo_rst_d;
        end
    end

    assign rdy        = rdy_q;
    assign src_addr   = src_cnt_q[AW-1:0];
    assign src_en     = src_en_q;
    assign fifo_rst   = fifo_rst_q;
    assign fifo_wr_en = wr_en_q;
    assign fifo_rd_en = rd_en;
    assign dst_addr   = dst_cnt_q[AW-1:0];
    assign dst_wr_en  = dst_wr_q;

endmodule

// File: tb/tb_modexpa7_fifo_mover.sv
// Bench for modexpa7_fifo_mover: bank/FIFO environment models, a queue
// scoreboard for FIFO contents, and directed plus randomized copies.
module tb_modexpa7_fifo_mover;
    localparam int AW   = 5;
    localparam int DB   = 2;
    localparam int NW   = 4;
    localparam int MAXC = 400;

    logic          clk = 1'b0;
    logic          rst, ena, rdy, src_en, fifo_rst, fifo_wr_en, fifo_rd_en;
    logic          dst_ready, dst_wr_en;
    logic [AW-1:0] n_num_words, src_addr, dst_addr;

    always #5 clk = ~clk;

    modexpa7_fifo_mover #(.OPERAND_ADDR_WIDTH(AW), .DEPTH_BITS(DB)) dut (
        .clk(clk), .rst(rst), .ena(ena), .rdy(rdy), .n_num_words(n_num_words),
        .src_addr(src_addr), .src_en(src_en), .fifo_rst(fifo_rst),
        .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .dst_ready(dst_ready),
        .dst_addr(dst_addr), .dst_wr_en(dst_wr_en)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit src_h[MAXC], wr_h[MAXC], rd_h[MAXC], dwr_h[MAXC], frst_h[MAXC], rdy_h[MAXC];
    int rdy_cyc, max_occ, src_idx, dst_idx;
    logic [31:0] src_mem[32], dst_mem[32], fifo_mem[NW];
    logic [31:0] src_dout, fifo_dout;
    int wp, rp;
    logic [31:0] q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit hv(input int sel, input int c);
        case (sel)
            0: return src_h[c];
            1: return wr_h[c];
            2: return rd_h[c];
            3: return dwr_h[c];
            4: return frst_h[c];
            default: return rdy_h[c];
        endcase
    endfunction

    function automatic int cnt(input int sel, input int lo, input int hi);
        int s = 0;
        for (int c = lo; c <= hi; c++) s += int'(hv(sel, c));
        return s;
    endfunction

    function automatic int first(input int sel);
        for (int c = 1; c < MAXC; c++) if (hv(sel, c)) return c;
        return -1;
    endfunction

    function automatic int last(input int sel);
        for (int c = MAXC - 1; c >= 1; c--) if (hv(sel, c)) return c;
        return -1;
    endfunction

    // Observes cycle c and applies the edge that ends it to the bank/FIFO models.
    task automatic sample_and_model(input int c);
        logic [31:0] ns, nf;
        ns = src_dout;
        nf = fifo_dout;
        src_h[c] = src_en; wr_h[c] = fifo_wr_en; rd_h[c] = fifo_rd_en;
        dwr_h[c] = dst_wr_en; frst_h[c] = fifo_rst; rdy_h[c] = rdy;
        if (dst_wr_en) begin
            check("dst_addr", 32'(dst_addr), dst_idx);
            if (dst_idx < 32) check("dst_data", fifo_dout, src_mem[dst_idx]);
            dst_mem[dst_addr] = fifo_dout;
            dst_idx++;
        end
        if (fifo_rd_en) begin
            check("no_underflow", (q.size() != 0) ? 1 : 0, 1);
            nf = fifo_mem[rp];
            if (q.size() != 0) void'(q.pop_front());
            rp = (rp + 1) % NW;
        end
        if (fifo_wr_en) begin
            fifo_mem[wp] = src_dout;
            wp = (wp + 1) % NW;
            q.push_back(src_dout);
            if (q.size() > max_occ) max_occ = q.size();
        end
        if (src_en) begin
            check("src_addr", 32'(src_addr), src_idx);
            ns = src_mem[src_addr];
            src_idx++;
        end
        if (fifo_rst) begin
            wp = 0; rp = 0; q.delete();
        end
        src_dout  = ns;
        fifo_dout = nf;
    endtask

    // mode 0: dst_ready=1; 1: dst_ready low in cycles 3..12; 2: random.
    task automatic run_copy(input int n, input int mode, input bit hold, input int rst_at);
        for (int i = 0; i < 32; i++) begin
            src_mem[i] = $urandom;
            dst_mem[i] = 'x;
        end
        for (int c = 0; c < MAXC; c++) begin
            src_h[c] = 0; wr_h[c] = 0; rd_h[c] = 0; dwr_h[c] = 0; frst_h[c] = 0; rdy_h[c] = 0;
        end
        src_idx = 0; dst_idx = 0; max_occ = 0; rdy_cyc = -1;
        n_num_words = AW'(n);
        ena = 1'b1;
        dst_ready = 1'b1;
        @(posedge clk); #1;
        if (!hold) ena = 1'b0;
        for (int c = 1; c < MAXC; c++) begin
            case (mode)
                0: dst_ready = 1'b1;
                1: dst_ready = !(c >= 3 && c <= 12);
                default: dst_ready = 1'($urandom_range(0, 1));
            endcase
            if (rst_at > 0 && c == rst_at) rst = 1'b1;
            if (rst_at > 0 && c == rst_at + 1) rst = 1'b0;
            #1;
            sample_and_model(c);
            if (rdy && c > 1) begin
                rdy_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        if (rdy_cyc < 0) check("rdy_timeout", 0, 1);
    endtask

    task automatic check_data(input int n);
        for (int i = 0; i <= n; i++) check("dst_word", dst_mem[i], src_mem[i]);
    endtask

    initial begin
        int nr;
        bit seen;
        rst = 1'b1; ena = 1'b0; dst_ready = 1'b1; n_num_words = '0;
        src_dout = '0; fifo_dout = '0; wp = 0; rp = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", rdy, 1);
        check("rst_src_en", src_en, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_dst_wr", dst_wr_en, 0);
        check("rst_fifo_rst", fifo_rst, 1);
        check("rst_src_addr", 32'(src_addr), 0);
        check("rst_dst_addr", 32'(dst_addr), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Eight-word copy, no back-pressure.
        run_copy(7, 0, 0, 0);
        check("n7_rdy_cycle", rdy_cyc, 14);
        check("n7_src_first", first(0), 2);  check("n7_src_last", last(0), 9);
        check("n7_src_cnt", cnt(0, 1, MAXC - 1), 8);
        check("n7_wr_first", first(1), 3);   check("n7_wr_last", last(1), 10);
        check("n7_rd_first", first(2), 4);   check("n7_rd_last", last(2), 11);
        check("n7_dwr_first", first(3), 5);  check("n7_dwr_last", last(3), 12);
        check("n7_dwr_cnt", cnt(3, 1, MAXC - 1), 8);
        check("n7_clear", first(4), 1);      check("n7_clear_cnt", cnt(4, 1, MAXC - 1), 1);
        check("n7_done_busy", rdy_h[13], 0);
        check_data(7);

        // Single-word copy.
        run_copy(0, 0, 0, 0);
        check("n0_rdy_cycle", rdy_cyc, 7);
        for (int s = 0; s < 4; s++) check("n0_pulse_cnt", cnt(s, 1, MAXC - 1), 1);
        check("n0_src_first", first(0), 2);
        check("n0_dwr_first", first(3), 5);
        check_data(0);

        // Sixteen words with dst_ready low for cycles 3..12.
        run_copy(15, 1, 0, 0);
        check("stall_src_before", cnt(0, 2, 13), 4);
        check("stall_src_resume", src_h[14], 1);
        check("stall_no_wr_full", cnt(1, 7, 14), 0);
        check("stall_max_occ", max_occ, 4);
        check("stall_src_cnt", cnt(0, 1, MAXC - 1), 16);
        check("stall_dwr_cnt", cnt(3, 1, MAXC - 1), 16);
        check("stall_rdy_cycle", rdy_cyc, 31);
        check_data(15);

        // Full-size copy with random back-pressure, then a few random lengths.
        run_copy(31, 2, 0, 0);
        check("rnd_occ_bound", (max_occ <= NW) ? 1 : 0, 1);
        check("rnd_src_cnt", cnt(0, 1, MAXC - 1), 32);
        check("rnd_dwr_cnt", cnt(3, 1, MAXC - 1), 32);
        check("rnd_min_latency", (rdy_cyc >= 38) ? 1 : 0, 1);
        check_data(31);
        for (int k = 0; k < 3; k++) begin
            nr = $urandom_range(0, 31);
            run_copy(nr, 2, 0, 0);
            check("rndn_occ_bound", (max_occ <= NW) ? 1 : 0, 1);
            check("rndn_dwr_cnt", cnt(3, 1, MAXC - 1), nr + 1);
            check_data(nr);
        end

        // Reset pulse in cycle 6 of a transfer, then a clean copy.
        run_copy(15, 0, 0, 6);
        check("rst_mid_active", src_h[6] & rd_h[6] & dwr_h[6], 1);
        check("rst_mid_rdy_cycle", rdy_cyc, 7);
        check("rst_mid_src", src_h[7], 0);
        check("rst_mid_wr", wr_h[7], 0);
        check("rst_mid_rd", rd_h[7], 0);
        check("rst_mid_dwr", dwr_h[7], 0);
        check("rst_mid_fifo_rst", frst_h[7], 1);
        run_copy(11, 0, 0, 0);
        check("post_rst_rdy_cycle", rdy_cyc, 18);
        check("post_rst_clear", first(4), 1);
        check("post_rst_clear_cnt", cnt(4, 1, MAXC - 1), 1);
        check_data(11);

        // ena held high: the next transfer starts only after DONE/IDLE.
        run_copy(2, 0, 1, 0);
        check("hold_rdy_cycle", rdy_cyc, 9);
        check("hold_clear_cnt", cnt(4, 1, 9), 1);
        check("hold_done_busy", rdy_h[8], 0);
        check_data(2);
        @(posedge clk); #1;
        check("hold_restart_clear", fifo_rst, 1);
        check("hold_restart_busy", rdy, 0);
        ena = 1'b0;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (rdy) begin
                seen = 1;
                break;
            end
        end
        check("hold_second_done", seen, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/modexpa7_fifo_mover.md
# modexpa7_fifo_mover

Transfer controller that sequences the modexpa7 small distributed-RAM FIFO (no full/empty flags, one-cycle registered read) to copy one multi-word operand from a source bank to a destination bank. It generates source-bank reads, FIFO write/read strobes, and destination-bank writes. It tracks occupancy so the FIFO never overflows or underflows, and it honours back-pressure from the destination side. It sits between operand banks inside the exponentiation core and is started by the top-level sequencer with the usual ena/rdy handshake.

## Interface
- OPERAND_ADDR_WIDTH, 5: width of word indices; max operand 2^OPERAND_ADDR_WIDTH words
- DEPTH_BITS, 2: FIFO address width; FIFO holds NUM_WORDS = 2^DEPTH_BITS words
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- ena  in  1  start request
- rdy  out  1  idle/done flag
- n_num_words  in  OPERAND_ADDR_WIDTH  operand length minus one; sampled at start
- src_addr  out  OPERAND_ADDR_WIDTH  source bank word index
- src_en  out  1  source bank read enable; data appears on FIFO d_in next cycle
- fifo_rst  out  1  FIFO pointer clear
- fifo_wr_en  out  1  FIFO write strobe
- fifo_rd_en  out  1  FIFO read strobe; FIFO d_out valid next cycle
- dst_ready  in  1  destination may accept a word; gates fifo_rd_en
- dst_addr  out  OPERAND_ADDR_WIDTH  destination bank word index
- dst_wr_en  out  1  destination bank write enable, aligned with FIFO d_out

## Operation
- Reset values: rdy=1; src_en, fifo_wr_en, fifo_rd_en, dst_wr_en = 0; fifo_rst=1 during reset; src_addr=0; dst_addr=0; FSM in IDLE.
- FSM states: IDLE, CLEAR, RUN, DONE.
  - IDLE -> CLEAR when ena=1 at a clock edge. n_num_words is latched and rdy falls.
  - CLEAR (1 cycle): fifo_rst=1, counters zeroed. Then -> RUN.
  - RUN -> DONE when the last destination write has been issued.
  - DONE (1 cycle) -> IDLE, with rdy=1.
- ena is ignored outside IDLE.
- Source issue: src_en=1 in RUN while src_cnt <= n_num_words and inflight < NUM_WORDS.
  - inflight = words read from source not yet popped from the FIFO.
  - src_addr = src_cnt; src_cnt increments on each src_en.
- fifo_wr_en = src_en delayed one cycle, registered.
- stored = words written to the FIFO not yet popped.
  - Increments on fifo_wr_en and decrements on fifo_rd_en.
  - Both in the same cycle: no change.
- fifo_rd_en=1 when stored > 0 and dst_ready=1.
- dst_wr_en = fifo_rd_en delayed one cycle; dst_addr increments after each dst_wr_en.
- Counter widths:
  - inflight: DEPTH_BITS+1 bits; must never exceed NUM_WORDS.
  - stored: DEPTH_BITS+1 bits; must never go negative.
  - src_cnt, dst_cnt: OPERAND_ADDR_WIDTH+1 bits, so the count n_num_words+1 is representable without wrap.
- FIFO pointers wrap naturally; the controller never relies on pointer values.
- Reset mid-transfer: all strobes drop in the next cycle, FSM returns to IDLE, rdy=1, and fifo_rst is held while rst=1. A partially written destination is left as is.

## Timing
- Cycle numbering: edge 0 is the edge at which ena is accepted; N = n_num_words+1.
- With dst_ready held at 1:
  - cycle 1: CLEAR.
  - src_en: cycles 2..N+1.
  - fifo_wr_en: cycles 3..N+2.
  - fifo_rd_en: cycles 4..N+3.
  - dst_wr_en: cycles 5..N+4.
  - rdy=1 from cycle N+6.
- Total: N+6 cycles from acceptance to rdy.
- Throughput is one word per cycle in steady state when dst_ready=1.
- A dst_ready low for k cycles adds exactly k cycles. src_en stalls once inflight reaches NUM_WORDS, and resumes the cycle after a pop.
- dst_ready is sampled combinationally into fifo_rd_en only; no other output depends combinationally on inputs.

## Structure
- Shared modexpa7 package holds:
  - FSM state encodings: FSM_STATE_IDLE, _CLEAR, _RUN, _DONE.
  - The NUM_WORDS derivation.
- Single module; no sub-module.
- The FIFO is instantiated by the parent alongside this controller.
- The occupancy counter pair (inflight/stored) may be factored into one small sub-module, modexpa7_fifo_occupancy, if reused by other movers.

## Test plan
- n_num_words=7, dst_ready=1, bench BRAM/FIFO models: src_en at cycles 2..9, dst_wr_en at 5..12, dst word i equals src word i, rdy back at cycle 14.
- n_num_words=0: single-word copy. Exactly one pulse each of src_en, fifo_wr_en, fifo_rd_en, dst_wr_en; rdy at cycle 7.
- n_num_words=15, dst_ready=0 for cycles 3..12:
  - src_en stops after 4 issues (inflight=4) and resumes one cycle after dst_ready rises.
  - No fifo write occurs while 4 words are stored.
  - All 16 words arrive correctly.
- Random dst_ready toggling, n_num_words=31: scoreboard shows no overflow (stored ≤ 4), no underflow, and correct order and addresses.
- rst asserted for one cycle during RUN at cycle 6:
  - All strobes are 0 the following cycle and rdy=1.
  - A new ena then completes a full copy correctly, with fifo_rst pulsed in CLEAR.
- ena held high continuously: back-to-back transfers start only from IDLE, with one DONE cycle between them.
